// File: rtl/multi_alarm_clock.sv
// 24-hour clock with NUM_ALARMS programmable alarms sharing one snooze/dismiss ringer.
// Define TWELVE_HR_EN to add the registered 12-hour outputs hrs12 and pm.
module multi_alarm_clock #(
    parameter int NUM_ALARMS = 4,
    parameter int TICK_DIV   = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    localparam int IDX_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            mode,
    input  logic [IDX_W-1:0]      alarm_idx,
    input  logic                  field_hrs,
    input  logic                  inc,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [7:0]            sec,
    output logic [7:0]            min,
    output logic [7:0]            hrs,
    output logic [7:0]            alrm_min,
    output logic [7:0]            alrm_hrs,
    output logic                  ringing,
    output logic [IDX_W-1:0]      ring_idx,
    output logic                  snoozed
`ifdef TWELVE_HR_EN
    ,
    output logic [7:0]            hrs12,
    output logic                  pm
`endif
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);
    localparam logic [11:0] SNZ_LOAD = 12'(SNOOZE_MIN * 60);

    localparam logic [1:0] MODE_RUN       = 2'b00;
    localparam logic [1:0] MODE_SET_TIME  = 2'b01;
    localparam logic [1:0] MODE_SET_ALARM = 2'b10;

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} ring_state_t;

    ring_state_t      state;
    logic [CNT_W-1:0] pre_cnt;
    logic             tick;
    logic             tick_d;
    logic [1:0]       mode_q;
    logic [7:0]       sec_n;
    logic [7:0]       min_n;
    logic [7:0]       hrs_n;
    logic [7:0]       al_min [NUM_ALARMS];
    logic [7:0]       al_hrs [NUM_ALARMS];
    logic             idx_ok;
    logic             match_any;
    logic [IDX_W-1:0] match_idx;
    logic             match_hit;
    logic [7:0]       ring_cnt;
    logic [11:0]      snz_cnt;

    assign idx_ok = (int'(alarm_idx) < NUM_ALARMS);
    assign tick   = (pre_cnt == CNT_LAST) && (mode != MODE_SET_TIME);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (mode == MODE_SET_TIME || pre_cnt == CNT_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Set-time edits fields without carry; every other mode lets the 1 Hz tick ripple.
    always_comb begin
        sec_n = sec;
        min_n = min;
        hrs_n = hrs;
        if (mode == MODE_SET_TIME) begin
            if (mode_q != MODE_SET_TIME) begin
                sec_n = 8'd0;
            end
            if (inc) begin
                if (field_hrs) begin
                    hrs_n = (hrs == 8'd23) ? 8'd0 : hrs + 8'd1;
                end else begin
                    min_n = (min == 8'd59) ? 8'd0 : min + 8'd1;
                end
            end
        end else if (tick) begin
            if (sec == 8'd59) begin
                sec_n = 8'd0;
                if (min == 8'd59) begin
                    min_n = 8'd0;
                    hrs_n = (hrs == 8'd23) ? 8'd0 : hrs + 8'd1;
                end else begin
                    min_n = min + 8'd1;
                end
            end else begin
                sec_n = sec + 8'd1;
            end
        end
    end

`ifdef TWELVE_HR_EN
    function automatic logic [7:0] to_twelve(input logic [7:0] h);
        if (h == 8'd0) begin
            return 8'd12;
        end else if (h > 8'd12) begin
            return h - 8'd12;
        end
        return h;
    endfunction
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec    <= 8'd0;
            min    <= 8'd0;
            hrs    <= 8'd0;
            mode_q <= MODE_RUN;
            tick_d <= 1'b0;
`ifdef TWELVE_HR_EN
            hrs12  <= 8'd12;
            pm     <= 1'b0;
`endif
        end else begin
            sec    <= sec_n;
            min    <= min_n;
            hrs    <= hrs_n;
            mode_q <= mode;
            tick_d <= tick;
`ifdef TWELVE_HR_EN
            hrs12  <= to_twelve(hrs_n);
            pm     <= (hrs_n >= 8'd12);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                al_min[i] <= 8'd0;
                al_hrs[i] <= 8'd0;
            end
        end else if (mode == MODE_SET_ALARM && inc && idx_ok) begin
            if (field_hrs) begin
                al_hrs[alarm_idx] <= (al_hrs[alarm_idx] == 8'd23) ? 8'd0 : al_hrs[alarm_idx] + 8'd1;
            end else begin
                al_min[alarm_idx] <= (al_min[alarm_idx] == 8'd59) ? 8'd0 : al_min[alarm_idx] + 8'd1;
            end
        end
    end

    always_comb begin
        alrm_min = 8'd0;
        alrm_hrs = 8'd0;
        if (idx_ok) begin
            alrm_min = al_min[alarm_idx];
            alrm_hrs = al_hrs[alarm_idx];
        end
    end

    // Scanning downward leaves the lowest matching slot as the winner.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_en[i] && al_min[i] == min && al_hrs[i] == hrs) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    assign match_hit = match_any && tick_d && (sec == 8'd0) && (mode == MODE_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ringing  <= 1'b0;
            snoozed  <= 1'b0;
            ring_idx <= '0;
            ring_cnt <= 8'd0;
            snz_cnt  <= 12'd0;
        end else if (mode != MODE_RUN) begin
            state    <= IDLE;
            ringing  <= 1'b0;
            snoozed  <= 1'b0;
            ring_cnt <= 8'd0;
            snz_cnt  <= 12'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (match_hit) begin
                        state    <= RINGING;
                        ringing  <= 1'b1;
                        ring_idx <= match_idx;
                        ring_cnt <= 8'd0;
                    end
                end
                RINGING: begin
                    if (dismiss || !alarm_en[ring_idx]) begin
                        state   <= IDLE;
                        ringing <= 1'b0;
                    end else if (snooze) begin
                        state   <= SNOOZED;
                        ringing <= 1'b0;
                        snoozed <= 1'b1;
                        snz_cnt <= SNZ_LOAD;
                    end else if (tick) begin
                        if (ring_cnt == RING_LAST) begin
                            state   <= IDLE;
                            ringing <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 8'd1;
                        end
                    end
                end
                SNOOZED: begin
                    if (dismiss || !alarm_en[ring_idx]) begin
                        state   <= IDLE;
                        snoozed <= 1'b0;
                    end else if (tick) begin
                        if (snz_cnt <= 12'd1) begin
                            state    <= RINGING;
                            snoozed  <= 1'b0;
                            ringing  <= 1'b1;
                            ring_cnt <= 8'd0;
                            snz_cnt  <= 12'd0;
                        end else begin
                            snz_cnt <= snz_cnt - 12'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ringing <= 1'b0;
                    snoozed <= 1'b0;
                end
            endcase
        end
    end

endmodule
